sprite_fetch_arbiter: RTL and testbench

Shares one bank of synchronous-read sprite pose ROMs between the two fighter pixel pipelines.
- Each requester asks for one pixel: pose, in-sprite x/y, horizontal flip.
- The arbiter grants one request per cycle, computes the ROM address and drives the bank.
- It returns the 4-bit palette index to the granted requester, tagged, with a fixed latency.
- It sits between the per-player sprite drawers and the pose ROM bank (stand/crouch/lowblock/punch, each 32x48 entries of 4 bits, 1-cycle registered read).

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_addr_gen.sv | 25 ++
 rtl/sprite_fetch_arbiter.sv | 149 ++++++++++++++
 tb/tb_sprite_fetch_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared geometry, pose and arbiter-state types for the sprite
// fetch path.
//   SPR_W / SPR_H  sprite size in pixels (SPR_W is a power of two)
//   PIX_W          palette index width
//   pose_t         pose ROM bank select
//   arb_state_t    ownership state of the fetch arbiter
package sprite_pkg;

    localparam int SPR_W    = 32;
    localparam int SPR_H    = 48;
    localparam int PIX_W    = 4;
    localparam int SPR_W_LG = $clog2(SPR_W);

    typedef enum logic [1:0] {
        POSE_STAND    = 2'd0,
        POSE_CROUCH   = 2'd1,
        POSE_LOWBLOCK = 2'd2,
        POSE_PUNCH    = 2'd3
    } pose_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: combinational pixel-to-ROM address mapping.
//   x, y     in-sprite coordinates (may lie outside the sprite)
//   flip     horizontal mirror
//   addr     y*SPR_W + x', with x' mirrored when flip is set
//   clipped  coordinate lies outside the sprite; addr is then meaningless
module sprite_addr_gen
    import sprite_pkg::*;
(
    input  logic [5:0]  x,
    input  logic [5:0]  y,
    input  logic        flip,
    output logic [10:0] addr,
    output logic        clipped
);

    logic [5:0] x_m;

    always_comb begin
        // Mirroring only has to be right for in-range x; out-of-range x is clipped.
        x_m     = flip ? (6'(SPR_W - 1) - x) : x;
        clipped = (x >= 6'(SPR_W)) || (y >= 6'(SPR_H));
        addr    = ({5'b0, y} << SPR_W_LG) + {5'b0, x_m};
    end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter: shares one synchronous-read pose ROM bank between the
// two fighter pixel pipelines, one pixel per cycle, fixed 3-cycle latency.
//   Clk, Reset        clock, synchronous active-high reset
//   req, lock         per-requester request / burst-ownership request
//   pose_k, px_x_k,   per-requester pose, in-sprite coordinates, mirror
//   px_y_k, flip
//   gnt               combinational one-hot grant (req&gnt = accepted)
//   rom_rd/pose/addr  registered ROM read strobe, bank select, address
//   rom_data          ROM output, valid the cycle after rom_rd
//   rsp_valid/pix     registered one-hot response strobe and palette index
module sprite_fetch_arbiter
    import sprite_pkg::*;
#(
    parameter int MAX_BURST = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       req,
    input  logic [1:0]       lock,
    input  pose_t            pose_0,
    input  pose_t            pose_1,
    input  logic [5:0]       px_x_0,
    input  logic [5:0]       px_x_1,
    input  logic [5:0]       px_y_0,
    input  logic [5:0]       px_y_1,
    input  logic [1:0]       flip,
    output logic [1:0]       gnt,
    output logic             rom_rd,
    output pose_t            rom_pose,
    output logic [10:0]      rom_addr,
    input  logic [PIX_W-1:0] rom_data,
    output logic [1:0]       rsp_valid,
    output logic [PIX_W-1:0] rsp_pix
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state, state_nxt;
    logic             rr_last, rr_last_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    logic             own, force_exit;

    logic             acc_p0, clip_p0;
    logic [5:0]       x_p0, y_p0;
    logic             flip_p0;
    pose_t            pose_p0;
    logic [10:0]      addr_p0;

    logic             vld_p1, id_p1, clip_p1;
    logic             vld_p2, id_p2, clip_p2;

    always_comb begin
        gnt           = 2'b00;
        state_nxt     = state;
        rr_last_nxt   = rr_last;
        burst_cnt_nxt = burst_cnt;
        own           = (state == OWN1);
        force_exit    = 1'b0;
        case (state)
            IDLE: begin
                // rr_last=1 means requester 0 wins a tie.
                if (req[0] && (!req[1] || rr_last))
                    gnt = 2'b01;
                else if (req[1])
                    gnt = 2'b10;
                if (gnt != 2'b00) begin
                    rr_last_nxt = gnt[1];
                    if ((lock & gnt) != 2'b00) begin
                        state_nxt     = gnt[1] ? OWN1 : OWN0;
                        burst_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            OWN0, OWN1: begin
                // A full burst yields to a waiting partner: this cycle is a
                // bubble and the partner wins the next IDLE tie.
                force_exit = (burst_cnt == BURST_MAX) && req[~own];
                if (req[own] && !force_exit) begin
                    gnt[own]    = 1'b1;
                    rr_last_nxt = own;
                    if (burst_cnt != BURST_MAX)
                        burst_cnt_nxt = burst_cnt + 1'b1;
                end
                if (!req[own] || !lock[own] || force_exit) begin
                    state_nxt   = IDLE;
                    rr_last_nxt = own;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: grant mux and address generation.
    always_comb begin
        acc_p0  = (gnt != 2'b00);
        x_p0    = gnt[1] ? px_x_1 : px_x_0;
        y_p0    = gnt[1] ? px_y_1 : px_y_0;
        flip_p0 = gnt[1] ? flip[1] : flip[0];
        pose_p0 = gnt[1] ? pose_1 : pose_0;
    end

    sprite_addr_gen u_addr_gen (
        .x       (x_p0),
        .y       (y_p0),
        .flip    (flip_p0),
        .addr    (addr_p0),
        .clipped (clip_p0)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            burst_cnt <= '0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            rom_rd    <= 1'b0;
            rom_pose  <= POSE_STAND;
            rom_addr  <= '0;
            rsp_valid <= 2'b00;
            rsp_pix   <= '0;
        end else begin
            state     <= state_nxt;
            rr_last   <= rr_last_nxt;
            burst_cnt <= burst_cnt_nxt;
            // Stage p1: ROM request registered.
            vld_p1    <= acc_p0;
            rom_rd    <= acc_p0 && !clip_p0;
            if (acc_p0) begin
                rom_pose <= pose_p0;
                rom_addr <= addr_p0;
            end
            // Stage p2: ROM data valid.
            vld_p2    <= vld_p1;
            // Stage p3: response registered.
            rsp_valid <= vld_p2 ? (id_p2 ? 2'b10 : 2'b01) : 2'b00;
            rsp_pix   <= (vld_p2 && !clip_p2) ? rom_data : '0;
        end
    end

    always_ff @(posedge Clk) begin
        id_p1   <= gnt[1];
        clip_p1 <= clip_p0;
        id_p2   <= id_p1;
        clip_p2 <= clip_p1;
    end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
module tb_sprite_fetch_arbiter;
    import sprite_pkg::*;

    localparam int MAXB = 32;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  req = 2'b00, lock = 2'b00, flip = 2'b00;
    pose_t       pose_0 = POSE_STAND, pose_1 = POSE_STAND;
    logic [5:0]  px_x_0 = '0, px_x_1 = '0, px_y_0 = '0, px_y_1 = '0;
    logic [1:0]  gnt, rsp_valid;
    logic        rom_rd;
    pose_t       rom_pose;
    logic [10:0] rom_addr;
    logic [3:0]  rom_data = '0, rsp_pix;

    sprite_fetch_arbiter #(.MAX_BURST(MAXB)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .lock(lock),
        .pose_0(pose_0), .pose_1(pose_1),
        .px_x_0(px_x_0), .px_x_1(px_x_1), .px_y_0(px_y_0), .px_y_1(px_y_1),
        .flip(flip), .gnt(gnt), .rom_rd(rom_rd), .rom_pose(rom_pose),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .rsp_valid(rsp_valid), .rsp_pix(rsp_pix)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] rom_fn(input int p, input int a);
        return 4'((a * 5 + p * 11 + (a >> 3)) & 15);
    endfunction

    // External ROM bank: 1-cycle registered read, garbage when not read.
    always @(posedge Clk)
        rom_data <= rom_rd ? rom_fn(int'(rom_pose), int'(rom_addr)) : 4'($urandom);

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner -1 = nobody holds the bank.
    int m_owner = -1, m_run = 0, m_last = 1;
    int e_vld[3], e_id[3], e_rd[3], e_addr[3], e_pose[3], e_pix[3];
    logic [1:0] obs_gnt, obs_rsp;

    function automatic logic [1:0] model_grant();
        logic [1:0] g;
        int o, c;
        g = 2'b00;
        if (m_owner >= 0) begin
            o = m_owner;
            if (m_run == MAXB && req[1-o]) begin
                m_last = o; m_owner = -1;
            end else if (!req[o]) begin
                m_last = o; m_owner = -1;
            end else begin
                g[o] = 1'b1; m_last = o;
                if (m_run < MAXB) m_run++;
                if (!lock[o]) m_owner = -1;
            end
        end else begin
            c = -1;
            if (req == 2'b11) c = 1 - m_last;
            else if (req[0]) c = 0;
            else if (req[1]) c = 1;
            if (c >= 0) begin
                g[c] = 1'b1; m_last = c;
                if (lock[c]) begin m_owner = c; m_run = 1; end
            end
        end
        return g;
    endfunction

    // One clock: check gnt before the edge, registered outputs after it.
    task automatic tick();
        logic [1:0] mg;
        int id, x, y, f, p, a, clip;
        logic rst_now;
        #1;
        mg = model_grant();
        chk("gnt", gnt, mg);
        obs_gnt = gnt;
        id = mg[1];
        x = id ? int'(px_x_1) : int'(px_x_0);
        y = id ? int'(px_y_1) : int'(px_y_0);
        f = id ? int'(flip[1]) : int'(flip[0]);
        p = id ? int'(pose_1) : int'(pose_0);
        a = y * SPR_W + (f != 0 ? SPR_W - 1 - x : x);
        clip = (x >= SPR_W || y >= SPR_H) ? 1 : 0;
        rst_now = Reset;
        @(posedge Clk);
        for (int s = 2; s > 0; s--) begin
            e_vld[s] = e_vld[s-1]; e_id[s] = e_id[s-1]; e_rd[s] = e_rd[s-1];
            e_addr[s] = e_addr[s-1]; e_pose[s] = e_pose[s-1]; e_pix[s] = e_pix[s-1];
        end
        e_vld[0] = (mg != 2'b00) ? 1 : 0;
        e_id[0] = id;
        e_rd[0] = (e_vld[0] != 0 && clip == 0) ? 1 : 0;
        e_addr[0] = a; e_pose[0] = p;
        e_pix[0] = clip != 0 ? 0 : int'(rom_fn(p, a));
        if (rst_now) begin
            m_owner = -1; m_run = 0; m_last = 1;
            for (int s = 0; s < 3; s++) begin e_vld[s] = 0; e_rd[s] = 0; end
        end
        @(negedge Clk);
        chk("rom_rd", rom_rd, e_rd[0]);
        if (e_rd[0] != 0) begin
            chk("rom_addr", rom_addr, e_addr[0]);
            chk("rom_pose", rom_pose, e_pose[0]);
        end
        chk("rsp_valid", rsp_valid, e_vld[2] != 0 ? (e_id[2] != 0 ? 2 : 1) : 0);
        if (e_vld[2] != 0) chk("rsp_pix", rsp_pix, e_pix[2]);
        if (rst_now) begin
            chk("rst_addr", rom_addr, 0);
            chk("rst_pose", rom_pose, 0);
            chk("rst_pix", rsp_pix, 0);
        end
        obs_rsp = rsp_valid;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] l,
                         input int p0, input int x0, input int y0, input int f0,
                         input int p1, input int x1, input int y1, input int f1);
        req = r; lock = l;
        pose_0 = pose_t'(p0); px_x_0 = 6'(x0); px_y_0 = 6'(y0);
        pose_1 = pose_t'(p1); px_x_1 = 6'(x1); px_y_1 = 6'(y1);
        flip = {f1 != 0, f0 != 0};
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        Reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] req, lock;
        int p0, x0, y0, f0, p1, x1, y1, f1;
        logic [1:0] gnt;
        int rd, addr, rpose;
        logic [1:0] rsp;
        int pix;
    } vec_t;

    vec_t tbl[10];
    logic [1:0] gh[64], rh[64];

    initial begin
        int run, k;
        tbl[0] = '{2'b01, 2'b00, 1, 3, 2, 0, 0, 0, 0, 0, 2'b01, 1, 67, 1, 2'b01, int'(rom_fn(1, 67))};
        tbl[1] = '{2'b01, 2'b00, 1, 3, 2, 1, 0, 0, 0, 0, 2'b01, 1, 92, 1, 2'b01, int'(rom_fn(1, 92))};
        tbl[2] = '{2'b01, 2'b00, 0, 40, 5, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 2'b01, 0};
        tbl[3] = '{2'b10, 2'b00, 0, 0, 0, 0, 3, 31, 47, 0, 2'b10, 1, 1535, 3, 2'b10, int'(rom_fn(3, 1535))};
        tbl[4] = '{2'b10, 2'b00, 0, 0, 0, 0, 2, 5, 10, 1, 2'b10, 1, 346, 2, 2'b10, int'(rom_fn(2, 346))};
        tbl[5] = '{2'b11, 2'b00, 0, 0, 0, 0, 3, 7, 7, 0, 2'b01, 1, 0, 0, 2'b01, int'(rom_fn(0, 0))};
        tbl[6] = '{2'b00, 2'b11, 1, 1, 1, 0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0};
        tbl[7] = '{2'b10, 2'b00, 0, 0, 0, 0, 1, 0, 48, 0, 2'b10, 0, 0, 0, 2'b10, 0};
        tbl[8] = '{2'b01, 2'b00, 2, 31, 0, 1, 0, 0, 0, 0, 2'b01, 1, 0, 2, 2'b01, int'(rom_fn(2, 0))};
        tbl[9] = '{2'b01, 2'b00, 1, 32, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 2'b01, 0};

        @(negedge Clk);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            do_reset();
            drive(tbl[i].req, tbl[i].lock, tbl[i].p0, tbl[i].x0, tbl[i].y0, tbl[i].f0,
                  tbl[i].p1, tbl[i].x1, tbl[i].y1, tbl[i].f1);
            tick();
            chk("vec_gnt", obs_gnt, tbl[i].gnt);
            chk("vec_rd", rom_rd, tbl[i].rd);
            if (tbl[i].rd != 0) begin
                chk("vec_addr", rom_addr, tbl[i].addr);
                chk("vec_pose", rom_pose, tbl[i].rpose);
            end
            drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
            tick(); tick();
            chk("vec_rsp", obs_rsp, tbl[i].rsp);
            if (tbl[i].rsp != 2'b00) chk("vec_pix", rsp_pix, tbl[i].pix);
        end

        // Alternating round-robin, responses in the same order 3 cycles later.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 6) drive(2'b11, 2'b00, i % 4, i, i + 1, i % 2, 3 - i % 4, 20 + i, 30 + i, 0);
            else drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            gh[i] = obs_gnt; rh[i] = obs_rsp;
        end
        for (int i = 0; i < 6; i++) begin
            chk("alt_gnt", gh[i], (i % 2) != 0 ? 2 : 1);
            chk("alt_rsp", rh[i+2], (i % 2) != 0 ? 2 : 1);
        end

        // Locked burst by requester 0 with requester 1 waiting.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(2'b11, 2'b01, 1, i % 32, i % 48, 0, 2, 4, 4, 1);
            tick();
            gh[i] = obs_gnt;
        end
        run = 0; k = 0;
        while (k < 40 && gh[k] == 2'b01) begin run++; k++; end
        chk("burst_len", run, 32);
        while (k < 40 && gh[k] == 2'b00) k++;
        chk("burst_handover", k < 40 ? int'(gh[k]) : 0, 2);
        k++;
        while (k < 40 && gh[k] == 2'b00) k++;
        chk("burst_back_idle", k < 40 ? int'(gh[k]) : 0, 1);

        // Reset with two fetches in flight.
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        drive(2'b01, 2'b00, 1, 3, 2, 0, 0, 0, 0, 0); tick();
        drive(2'b10, 2'b00, 0, 0, 0, 0, 2, 9, 9, 0); tick();
        Reset = 1'b1;
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("rst_rd", rom_rd, 0);
        chk("rst_rsp0", obs_rsp, 0);
        Reset = 1'b0;
        tick();
        chk("rst_rsp1", obs_rsp, 0);
        tick();
        chk("rst_rsp2", obs_rsp, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 299) == 0);
            drive(2'($urandom), {$urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7},
                  $urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 55), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 55), $urandom_range(0, 1));
            tick();
        end
        Reset = 1'b0;
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
